// File: rtl/bnn_stream_pkg.sv
// Shared types, widths and the sample quantizer for the BNN feature streamer.
package bnn_stream_pkg;

    localparam int FEAT_CNT  = 16;
    localparam int FEAT_BITS = 4;
    localparam int RAW_BITS  = 8;
    localparam int CLASS_CNT = 10;

    localparam int SH        = RAW_BITS - FEAT_BITS;
    localparam int SUM_BITS  = RAW_BITS + 1;
    localparam int PRED_BITS = $clog2(CLASS_CNT);
    localparam int VEC_BITS  = FEAT_CNT * FEAT_BITS;
    localparam int CNT_BITS  = $clog2(FEAT_CNT);

    localparam logic [SUM_BITS-1:0] ROUND_HALF = {{(SUM_BITS-1){1'b0}}, 1'b1} << (SH - 1);
    localparam logic [SUM_BITS-1:0] Q_MAX      = {{(SUM_BITS-FEAT_BITS){1'b0}}, {FEAT_BITS{1'b1}}};

    typedef enum logic [1:0] {
        CLS_IDLE = 2'd0,
        CLS_RUN  = 2'd1,
        CLS_DONE = 2'd2
    } cls_state_e;

    // Round-to-nearest then saturate; the extra sum bit keeps 0xFF from wrapping to 0.
    function automatic logic [FEAT_BITS-1:0] quantize(input logic [RAW_BITS-1:0] raw);
        logic [SUM_BITS-1:0] sum_s;
        logic [SUM_BITS-1:0] shr_s;
        sum_s = {1'b0, raw} + ROUND_HALF;
        shr_s = sum_s >> SH;
        if (shr_s > Q_MAX) begin
            quantize = {FEAT_BITS{1'b1}};
        end else begin
            quantize = shr_s[FEAT_BITS-1:0];
        end
    endfunction

endpackage

// File: rtl/bnn_feat_quant.sv
// Combinational wrapper around the package quantizer, kept separate for unit testing.
module bnn_feat_quant
    import bnn_stream_pkg::*;
(
    input  logic [RAW_BITS-1:0]  raw,
    output logic [FEAT_BITS-1:0] q
);

    assign q = quantize(raw);

endmodule

// File: rtl/bnn_feature_streamer.sv
// Packs quantized samples into frames, holds them for the classifier's fixed
// evaluation time, and streams out the captured prediction tagged with a frame id.
module bnn_feature_streamer
    import bnn_stream_pkg::*;
#(
    parameter int LATENCY = 64,
    parameter int ID_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [RAW_BITS-1:0]  s_data,
    output logic [VEC_BITS-1:0]  feat_vec,
    input  logic [PRED_BITS-1:0] cls_pred,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PRED_BITS-1:0] m_pred,
    output logic [ID_BITS-1:0]   m_id
);

    localparam int RUN_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [RUN_BITS-1:0] RUN_LOAD = RUN_BITS'(LATENCY - 1);
    localparam logic [RUN_BITS-1:0] RUN_ONE  = {{(RUN_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(FEAT_CNT - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [ID_BITS-1:0]  ID_ONE   = {{(ID_BITS-1){1'b0}}, 1'b1};

    logic [FEAT_BITS-1:0] q_s;
    logic                 beat_s;
    logic                 load_s;
    logic                 capture_s;
    cls_state_e           state_r;
    cls_state_e           state_nx_s;

    logic [VEC_BITS-1:0]  asm_r;
    logic [CNT_BITS-1:0]  asm_cnt_r;
    logic                 asm_full_r;
    logic [RUN_BITS-1:0]  run_cnt_r;
    logic [VEC_BITS-1:0]  feat_vec_r;
    logic                 m_valid_r;
    logic [PRED_BITS-1:0] m_pred_r;
    logic [ID_BITS-1:0]   m_id_r;
    logic [ID_BITS-1:0]   frame_id_r;

    bnn_feat_quant u_quant (
        .raw (s_data),
        .q   (q_s)
    );

    assign s_ready  = ~asm_full_r;
    assign beat_s   = s_valid & ~asm_full_r;
    assign feat_vec = feat_vec_r;
    assign m_valid  = m_valid_r;
    assign m_pred   = m_pred_r;
    assign m_id     = m_id_r;

    // Assembly buffer: a full frame stays parked until the classify side takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_r      <= {VEC_BITS{1'b0}};
            asm_cnt_r  <= {CNT_BITS{1'b0}};
            asm_full_r <= 1'b0;
        end else begin
            if (beat_s) begin
                asm_r[int'(asm_cnt_r)*FEAT_BITS +: FEAT_BITS] <= q_s;
                if (asm_cnt_r == CNT_LAST) begin
                    asm_cnt_r  <= {CNT_BITS{1'b0}};
                    asm_full_r <= 1'b1;
                end else begin
                    asm_cnt_r <= asm_cnt_r + CNT_ONE;
                end
            end else if (load_s) begin
                asm_full_r <= 1'b0;
            end
        end
    end

    // Classify state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= CLS_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Classify next-state decode plus load/capture strobes.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            CLS_IDLE: begin
                if (asm_full_r) begin
                    state_nx_s = CLS_RUN;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = CLS_IDLE;
                end
            end
            CLS_RUN: begin
                if (run_cnt_r == {RUN_BITS{1'b0}}) begin
                    state_nx_s = CLS_DONE;
                    capture_s  = 1'b1;
                end else begin
                    state_nx_s = CLS_RUN;
                end
            end
            CLS_DONE: begin
                if (m_ready) begin
                    state_nx_s = CLS_IDLE;
                end else begin
                    state_nx_s = CLS_DONE;
                end
            end
            default: begin
                state_nx_s = CLS_IDLE;
            end
        endcase
    end

    // Classify datapath: features frozen from load until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_r  <= {RUN_BITS{1'b0}};
            feat_vec_r <= {VEC_BITS{1'b0}};
            m_valid_r  <= 1'b0;
            m_pred_r   <= {PRED_BITS{1'b0}};
            m_id_r     <= {ID_BITS{1'b0}};
            frame_id_r <= {ID_BITS{1'b0}};
        end else begin
            if (load_s) begin
                feat_vec_r <= asm_r;
                run_cnt_r  <= RUN_LOAD;
            end else if (state_r == CLS_RUN) begin
                run_cnt_r <= run_cnt_r - RUN_ONE;
            end
            if (capture_s) begin
                m_pred_r   <= cls_pred;
                m_id_r     <= frame_id_r;
                frame_id_r <= frame_id_r + ID_ONE;
            end
            m_valid_r <= (state_nx_s == CLS_DONE);
        end
    end

endmodule

// File: tb/tb_bnn_feature_streamer.sv
// Randomized scoreboard bench for bnn_feature_streamer with a stub classifier.
module tb_bnn_feature_streamer;

    localparam int LAT = 4;

    typedef struct {
        logic [63:0] vec;
        logic [3:0]  pred;
        logic [7:0]  id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [63:0] feat_vec;
    logic [3:0]  cls_pred;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_pred;
    logic [7:0]  m_id;
    logic [7:0]  q_raw;
    logic [3:0]  q_out;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_beat_cyc = 0;
    int   rdy_mode = 0;
    bit   use_hash = 1'b0;
    bit   lat_chk = 1'b0;
    logic [3:0] pred_const = 4'd7;

    exp_t sb_q[$];
    logic [63:0] cur_vec = 64'd0;
    int   cur_cnt = 0;
    int   frame_no = 0;
    int   pops = 0;
    logic [7:0] last_id = 8'd0;

    bnn_feature_streamer #(.LATENCY(LAT), .ID_BITS(8)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .feat_vec(feat_vec), .cls_pred(cls_pred), .m_valid(m_valid), .m_ready(m_ready),
        .m_pred(m_pred), .m_id(m_id)
    );

    bnn_feat_quant u_q (.raw(q_raw), .q(q_out));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] q_model(input int r);
        int q;
        q = (r + 8) / 16;
        if (q > 15) q = 15;
        return 4'(q);
    endfunction

    // Stub classifier: digit sum of the feature nibbles, mod 10.
    function automatic logic [3:0] stub_cls(input logic [63:0] v);
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += int'(v[i*4 +: 4]);
        return 4'(s % 10);
    endfunction

    assign cls_pred = use_hash ? stub_cls(feat_vec) : pred_const;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [7:0] d);
        exp_t e;
        cur_vec[cur_cnt*4 +: 4] = q_model(int'(d));
        cur_cnt++;
        if (cur_cnt == 16) begin
            e.vec  = cur_vec;
            e.pred = use_hash ? stub_cls(cur_vec) : pred_const;
            e.id   = 8'(frame_no % 256);
            sb_q.push_back(e);
            frame_no++;
            cur_cnt = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat transferred.
    task automatic send_beat(input logic [7:0] d, input bit gap);
        bit acc;
        acc = 1'b0;
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        s_valid = 1'b1;
        s_data  = d;
        for (int w = 0; w < 500 && !acc; w++) begin
            @(negedge clk);
            acc = s_ready;
            if (acc) last_beat_cyc = cyc;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("beat_accept_timeout", 64'(acc), 64'd1);
        if (acc) model_accept(d);
    endtask

    task automatic wait_drain(input int budget);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < budget) begin @(posedge clk); #1; w++; end
        chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic model_reset();
        sb_q.delete();
        frame_no = 0;
        cur_cnt  = 0;
        cur_vec  = 64'd0;
        pops     = 0;
    endtask

    // Result-side ready driver, applied a little after each edge.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each result handshake and checks hold stability.
    initial begin
        exp_t e;
        bit mv_prev, mr_prev;
        logic [3:0]  p_pred;
        logic [7:0]  p_id;
        logic [63:0] p_vec;
        mv_prev = 1'b0; mr_prev = 1'b0; p_pred = 4'd0; p_id = 8'd0; p_vec = 64'd0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                mv_prev = 1'b0;
                continue;
            end
            if (m_valid && !mv_prev && lat_chk)
                chk("valid_latency", 64'(cyc - last_beat_cyc), 64'(LAT + 2));
            if (mv_prev && !mr_prev) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_pred", 64'(m_pred), 64'(p_pred));
                chk("hold_id", 64'(m_id), 64'(p_id));
                chk("hold_vec", feat_vec, p_vec);
            end
            if (m_valid && m_ready) begin
                chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("result_pred", 64'(m_pred), 64'(e.pred));
                    chk("result_id", 64'(m_id), 64'(e.id));
                    chk("result_vec", feat_vec, e.vec);
                    pops++;
                    last_id = m_id;
                end
            end
            mv_prev = m_valid; mr_prev = m_ready;
            p_pred = m_pred; p_id = m_id; p_vec = feat_vec;
        end
    end

    initial begin
        logic [7:0]  braw [5] = '{8'h00, 8'h07, 8'h08, 8'hF7, 8'hFF};
        logic [3:0]  bq   [5] = '{4'd0, 4'd0, 4'd1, 4'd15, 4'd15};
        logic [63:0] vec_a, vec_b;

        rst = 1'b0; s_valid = 1'b0; s_data = 8'd0; q_raw = 8'd0;
        repeat (2) @(posedge clk); #1;
        chk("por_s_ready", 64'(s_ready), 64'd1);
        chk("por_m_valid", 64'(m_valid), 64'd0);
        chk("por_feat_vec", feat_vec, 64'd0);
        chk("por_m_pred", 64'(m_pred), 64'd0);
        chk("por_m_id", 64'(m_id), 64'd0);
        rst = 1'b1;

        // Quantizer in isolation: full sweep plus named boundaries.
        for (int r = 0; r < 256; r++) begin
            q_raw = 8'(r); #1;
            chk("quant_sweep", 64'(q_out), 64'(q_model(r)));
        end
        for (int i = 0; i < 5; i++) begin
            q_raw = braw[i]; #1;
            chk("quant_boundary", 64'(q_out), 64'(bq[i]));
        end
        @(posedge clk); #1;

        // Single frame, constant prediction 7, exact latency.
        rdy_mode = 1; lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) send_beat(8'(i * 16), 1'b0);
        wait_drain(200);
        lat_chk = 1'b0;
        for (int i = 0; i < 16; i++) chk("single_nibble", 64'(feat_vec[i*4 +: 4]), 64'(i));

        // Boundary samples through the full path, random ready from here on.
        use_hash = 1'b1; rdy_mode = 2;
        for (int i = 0; i < 16; i++) send_beat(i < 5 ? braw[i] : 8'($urandom), 1'b1);
        wait_drain(300);
        for (int i = 0; i < 5; i++) chk("path_boundary", 64'(feat_vec[i*4 +: 4]), 64'(bq[i]));

        // Reset two cycles into RUN with a partial next frame pending.
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) send_beat(8'($urandom), 1'b0);
        for (int i = 0; i < 2; i++) send_beat(8'($urandom), 1'b0);
        #2 rst = 1'b0; #1;
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_feat_vec", feat_vec, 64'd0);
        chk("rst_m_pred", 64'(m_pred), 64'd0);
        chk("rst_m_id", 64'(m_id), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_valid_after_rst", 64'(m_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Backpressure: two frames with the result side stalled.
        rdy_mode = 0;
        for (int i = 0; i < 32; i++) send_beat(8'($urandom), 1'b0);
        vec_a = sb_q[0].vec;
        vec_b = sb_q[1].vec;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_s_ready", 64'(s_ready), 64'd0);
        chk("bp_m_valid", 64'(m_valid), 64'd1);
        chk("bp_feat_vec", feat_vec, vec_a);
        chk("bp_m_id", 64'(m_id), 64'd0);
        @(posedge clk); #1 rdy_mode = 1;
        @(posedge clk); #1 rdy_mode = 0;
        @(negedge clk);
        chk("bp_idle_valid", 64'(m_valid), 64'd0);
        chk("bp_idle_vec", feat_vec, vec_a);
        chk("bp_idle_s_ready", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("bp_run_vec", feat_vec, vec_b);
        chk("bp_run_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1 rdy_mode = 2;
        wait_drain(300);
        chk("bp_second_id", 64'(last_id), 64'd1);

        // Id wrap: 257 frames since reset, the last one tagged 0.
        for (int f = 0; f < 255; f++)
            for (int i = 0; i < 16; i++) send_beat(8'($urandom), ($urandom_range(0, 3) == 0));
        wait_drain(500);
        chk("wrap_frame_count", 64'(pops), 64'd257);
        chk("wrap_last_id", 64'(last_id), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
